background_pixel_shifter: RTL and testbench
===========================================

# background_pixel_shifter

Background pixel pipeline of the PPU. It sits directly downstream of the VRAM fetch controller and consumes the per-tile attribute and pattern bytes that controller latches every 8 dots. It holds two tiles of pattern and attribute data in shift registers and selects one bit column per dot using fine X. It emits a registered 4-bit background pixel (palette-select plus pattern bits) to the sprite/background priority mux.

## Interface
Parameters:
- None. Widths are fixed by the NES tile format.

Ports:
- clock  in  1  PPU master clock, shared with the fetch controller.
- reset_N  in  1  asynchronous, active-low reset.
- clock_EN  in  1  dot enable. All state updates only on cycles where it is high.
- shift_EN  in  1  shift all shifters one column this dot.
- reload_EN  in  1  load the latched tile into the low byte of the shifters this dot.
- tileAttribute_IN  in  2  2-bit palette select from the fetch controller.
- tileLowByte_IN  in  8  pattern plane 0 from the fetch controller.
- tileHighByte_IN  in  8  pattern plane 1 from the fetch controller.
- fineX_IN  in  3  fine X scroll (loopy x).
- showBackground_EN  in  1  PPUMASK bit 3.
- showLeft8_EN  in  1  PPUMASK bit 1.
- pixelX_IN  in  8  screen column of the pixel sampled this dot.
- pixel_OUT  out  4  {attrHi, attrLo, patHi, patLo}. 4'h0 means transparent.
- opaque_OUT  out  1  high when pixel_OUT[1:0] is nonzero.

## Operation
- State is four 16-bit shifters: patLow_REG, patHigh_REG, attrLow_REG, attrHigh_REG.
- Bits [15:8] hold the current tile and bits [7:0] hold the next tile. Shifting moves data toward the MSB.
- Per enabled dot, the update is selected by {shift_EN, reload_EN}:
  - 00: hold.
  - 10: each shifter becomes {old[14:0], 1'b0}.
  - 01: low byte is replaced. patLow[7:0]=tileLowByte_IN, patHigh[7:0]=tileHighByte_IN, attrLow[7:0]={8{tileAttribute_IN[0]}}, attrHigh[7:0]={8{tileAttribute_IN[1]}}. The upper byte is unchanged.
  - 11: shift and load. Result is {old[14:7], newByte}.
- Pixel select: bit index s = 15 - fineX_IN.
  - The raw pixel is {attrHigh[s], attrLow[s], patHigh[s], patLow[s]}, taken from the pre-update register values of the same enabled cycle.
- Masking forces pixel_OUT to 4'h0 when any of the following holds:
  - showBackground_EN=0;
  - showLeft8_EN=0 and pixelX_IN<8;
  - raw pattern bits are 2'b00. Palette bits are cleared so that universal background is reported as 0.
- opaque_OUT is derived from the registered pixel_OUT as |pixel_OUT[1:0]. It has no separate state.
- fineX_IN and the mask inputs may change on any dot. They take effect on the next enabled sample.

## Timing
- Reset (reset_N low, asynchronous): all shifters 16'h0000, pixel_OUT 4'h0, opaque_OUT 0. Reset takes effect immediately and is not gated by clock_EN.
- Release is synchronous in effect: the first enabled edge after reset_N rises operates normally.
- Reset asserted mid-line discards all shifter contents. The output stays 0 until two reloads plus shifts have refilled the pipeline.
- clock_EN low: every register holds regardless of shift_EN and reload_EN.
- pixel_OUT latency is 1 enabled cycle. The value sampled on enabled cycle k appears after edge k and holds until the next enabled edge.
- Tile latency with a reload-only at enable k, shifts on every later enable, and fineX=0:
  - tile column 0 appears on pixel_OUT after enable k+9;
  - column c appears after enable k+9+c.
- Fine X selects deeper bits. Column c of the current tile appears fineX dots earlier than it would with fineX=0.
- No handshake: the upstream controller guarantees that the tile inputs are stable on any dot where reload_EN is high.

## Test plan
- Reset: load patLow=16'hFFFF via reloads and shifts, then pulse reset_N low between clock edges. pixel_OUT=0 and opaque_OUT=0 immediately; all shifters read 0.
- Basic tile, fineX=0, masks enabled, pixelX≥8:
  - stimulus: reload-only with low=8'hA5, high=8'h0F, attr=2'b10; then 16 shift-only dots;
  - required: after enables 9–16, pixel_OUT = 9,0,9,0,A,B,A,B and opaque_OUT = 1,0,1,0,1,1,1,1.
- Fine X: same stimulus with fineX=3. After enables 9–13, pixel_OUT = 0,A,B,A,B; the following samples come from the next tile (all zero).
- Shift+reload: preset patLow=16'h1234, then shift_EN=reload_EN=1 with tileLowByte_IN=8'hCD. patLow becomes 16'h24CD; the attribute low byte equals the replicated input bits.
- Left mask: opaque tile loaded, showLeft8_EN=0, pixelX_IN sweeps 0–9. pixel_OUT=0 for columns 0–7 and nonzero for 8 and 9. With showBackground_EN=0, pixel_OUT=0 for all columns.
- Enable gating: after loading, hold clock_EN=0 for 5 cycles with shift_EN=1. The shifters and pixel_OUT are unchanged; the sequence resumes exactly when clock_EN returns.

Source files
------------

// File: rtl/background_pixel_shifter.sv
// ============================================================================
// Module      : background_pixel_shifter
// Description : PPU background shifters; selects one tile column per dot
//               via fine X and registers the masked 4-bit background pixel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module background_pixel_shifter (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       clock_EN,
  input  logic       shift_EN,
  input  logic       reload_EN,
  input  logic [1:0] tileAttribute_IN,
  input  logic [7:0] tileLowByte_IN,
  input  logic [7:0] tileHighByte_IN,
  input  logic [2:0] fineX_IN,
  input  logic       showBackground_EN,
  input  logic       showLeft8_EN,
  input  logic [7:0] pixelX_IN,
  output logic [3:0] pixel_OUT,
  output logic       opaque_OUT
);

  // Bits [15:8] hold the tile on screen now, [7:0] the tile arriving next.
  logic [15:0] pat_low;
  logic [15:0] pat_high;
  logic [15:0] attr_low;
  logic [15:0] attr_high;
  logic [3:0]  pixel_reg;

  logic [15:0] pat_low_next;
  logic [15:0] pat_high_next;
  logic [15:0] attr_low_next;
  logic [15:0] attr_high_next;

  logic [3:0]  sel;
  logic [3:0]  raw_pixel;
  logic        left_clip;
  logic        pixel_visible;
  logic [3:0]  pixel_next;

  function automatic logic [15:0] next_shifter(
    input logic [15:0] cur,
    input logic [7:0]  fill,
    input logic        do_shift,
    input logic        do_reload
  );
    logic [15:0] result;
    case ({do_shift, do_reload})
      2'b10:   result = {cur[14:0], 1'b0};
      2'b01:   result = {cur[15:8], fill};
      2'b11:   result = {cur[14:7], fill};
      default: result = cur;
    endcase
    return result;
  endfunction

  always_comb begin
    pat_low_next   = next_shifter(pat_low,   tileLowByte_IN,             shift_EN, reload_EN);
    pat_high_next  = next_shifter(pat_high,  tileHighByte_IN,            shift_EN, reload_EN);
    attr_low_next  = next_shifter(attr_low,  {8{tileAttribute_IN[0]}},   shift_EN, reload_EN);
    attr_high_next = next_shifter(attr_high, {8{tileAttribute_IN[1]}},   shift_EN, reload_EN);
  end

  // Pixel is taken from the pre-update shifter contents of the same dot.
  always_comb begin
    sel           = 4'd15 - {1'b0, fineX_IN};
    raw_pixel     = {attr_high[sel], attr_low[sel], pat_high[sel], pat_low[sel]};
    left_clip     = !showLeft8_EN && (pixelX_IN < 8'd8);
    pixel_visible = showBackground_EN && !left_clip && (raw_pixel[1:0] != 2'b00);
    pixel_next    = pixel_visible ? raw_pixel : 4'h0;
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pat_low   <= 16'h0000;
      pat_high  <= 16'h0000;
      attr_low  <= 16'h0000;
      attr_high <= 16'h0000;
      pixel_reg <= 4'h0;
    end else if (clock_EN) begin
      pat_low   <= pat_low_next;
      pat_high  <= pat_high_next;
      attr_low  <= attr_low_next;
      attr_high <= attr_high_next;
      pixel_reg <= pixel_next;
    end
  end

  assign pixel_OUT  = pixel_reg;
  assign opaque_OUT = |pixel_reg[1:0];

endmodule

`default_nettype wire

// File: tb/tb_background_pixel_shifter.sv
// ============================================================================
// Module      : tb_background_pixel_shifter
// Description : Directed self-checking bench for background_pixel_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_background_pixel_shifter;

  logic       clock;
  logic       reset_N;
  logic       clock_EN;
  logic       shift_EN;
  logic       reload_EN;
  logic [1:0] tileAttribute_IN;
  logic [7:0] tileLowByte_IN;
  logic [7:0] tileHighByte_IN;
  logic [2:0] fineX_IN;
  logic       showBackground_EN;
  logic       showLeft8_EN;
  logic [7:0] pixelX_IN;
  logic [3:0] pixel_OUT;
  logic       opaque_OUT;

  int errors = 0;
  int checks = 0;

  logic [3:0] basic_pix [8] = '{4'h9, 4'h0, 4'h9, 4'h0, 4'hA, 4'hB, 4'hA, 4'hB};
  logic       basic_opq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] finex_pix [6] = '{4'h0, 4'hA, 4'hB, 4'hA, 4'hB, 4'h0};

  background_pixel_shifter dut (
    .clock             (clock),
    .reset_N           (reset_N),
    .clock_EN          (clock_EN),
    .shift_EN          (shift_EN),
    .reload_EN         (reload_EN),
    .tileAttribute_IN  (tileAttribute_IN),
    .tileLowByte_IN    (tileLowByte_IN),
    .tileHighByte_IN   (tileHighByte_IN),
    .fineX_IN          (fineX_IN),
    .showBackground_EN (showBackground_EN),
    .showLeft8_EN      (showLeft8_EN),
    .pixelX_IN         (pixelX_IN),
    .pixel_OUT         (pixel_OUT),
    .opaque_OUT        (opaque_OUT)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One enabled dot; returns 1 time unit after the active edge.
  task automatic dot(input logic s, input logic r);
    clock_EN  = 1'b1;
    shift_EN  = s;
    reload_EN = r;
    @(posedge clock);
    #1;
  endtask

  task automatic load_tile(input logic [7:0] lo, input logic [7:0] hi, input logic [1:0] at);
    tileLowByte_IN   = lo;
    tileHighByte_IN  = hi;
    tileAttribute_IN = at;
    dot(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    clock_EN          = 1'b0;
    shift_EN          = 1'b0;
    reload_EN         = 1'b0;
    tileAttribute_IN  = 2'b00;
    tileLowByte_IN    = 8'h00;
    tileHighByte_IN   = 8'h00;
    fineX_IN          = 3'd0;
    showBackground_EN = 1'b1;
    showLeft8_EN      = 1'b1;
    pixelX_IN         = 8'd20;
    @(negedge clock);
    reset_N = 1'b0;
    #2;
    reset_N = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    load_tile(8'hFF, 8'h00, 2'b00);
    for (int i = 0; i < 8; i++) dot(1'b1, 1'b0);
    load_tile(8'hFF, 8'h00, 2'b00);
    checks++;
    if (dut.pat_low !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_preload pat_low got %h want %h", dut.pat_low, 16'hFFFF);
    end
    dot(1'b0, 1'b0);
    checks++;
    if (pixel_OUT !== 4'h1 || opaque_OUT !== 1'b1) begin
      errors++;
      $display("FAIL reset_prepixel got %h/%b want 1/1", pixel_OUT, opaque_OUT);
    end
    #2;
    reset_N = 1'b0;
    #1;
    checks++;
    if (pixel_OUT !== 4'h0 || opaque_OUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_pixel got %h/%b want 0/0", pixel_OUT, opaque_OUT);
    end
    checks++;
    if (dut.pat_low !== 16'h0 || dut.pat_high !== 16'h0 ||
        dut.attr_low !== 16'h0 || dut.attr_high !== 16'h0) begin
      errors++;
      $display("FAIL reset_shifters got %h %h %h %h want all 0000",
               dut.pat_low, dut.pat_high, dut.attr_low, dut.attr_high);
    end
    #1;
    reset_N = 1'b1;
    dot(1'b0, 1'b0);
    checks++;
    if (pixel_OUT !== 4'h0) begin
      errors++;
      $display("FAIL reset_release_pixel got %h want 0", pixel_OUT);
    end
  endtask

  task automatic test_basic_tile();
    do_reset();
    load_tile(8'hA5, 8'h0F, 2'b10);
    for (int j = 1; j <= 16; j++) begin
      dot(1'b1, 1'b0);
      if (j == 4) begin
        checks++;
        if (pixel_OUT !== 4'h0) begin
          errors++;
          $display("FAIL basic_early enable %0d got %h want 0", j, pixel_OUT);
        end
      end
      if (j >= 9) begin
        checks++;
        if (pixel_OUT !== basic_pix[j-9] || opaque_OUT !== basic_opq[j-9]) begin
          errors++;
          $display("FAIL basic_tile enable %0d got %h/%b want %h/%b",
                   j, pixel_OUT, opaque_OUT, basic_pix[j-9], basic_opq[j-9]);
        end
      end
    end
  endtask

  task automatic test_fine_x();
    do_reset();
    fineX_IN = 3'd3;
    load_tile(8'hA5, 8'h0F, 2'b10);
    for (int j = 1; j <= 14; j++) begin
      dot(1'b1, 1'b0);
      if (j >= 9) begin
        checks++;
        if (pixel_OUT !== finex_pix[j-9]) begin
          errors++;
          $display("FAIL fine_x enable %0d got %h want %h", j, pixel_OUT, finex_pix[j-9]);
        end
      end
    end
  endtask

  task automatic test_shift_reload();
    do_reset();
    load_tile(8'h12, 8'h00, 2'b00);
    for (int i = 0; i < 8; i++) dot(1'b1, 1'b0);
    load_tile(8'h34, 8'h00, 2'b00);
    tileLowByte_IN   = 8'hCD;
    tileHighByte_IN  = 8'h5A;
    tileAttribute_IN = 2'b01;
    dot(1'b1, 1'b1);
    checks++;
    if (dut.pat_low !== 16'h24CD) begin
      errors++;
      $display("FAIL shift_reload pat_low got %h want 24cd", dut.pat_low);
    end
    checks++;
    if (dut.pat_high !== 16'h005A) begin
      errors++;
      $display("FAIL shift_reload pat_high got %h want 005a", dut.pat_high);
    end
    checks++;
    if (dut.attr_low !== 16'h00FF || dut.attr_high !== 16'h0000) begin
      errors++;
      $display("FAIL shift_reload attr got %h/%h want 00ff/0000", dut.attr_low, dut.attr_high);
    end
  endtask

  task automatic test_left_mask();
    do_reset();
    load_tile(8'hFF, 8'hFF, 2'b11);
    for (int i = 0; i < 8; i++) dot(1'b1, 1'b0);
    showLeft8_EN = 1'b0;
    for (int x = 0; x < 10; x++) begin
      pixelX_IN = 8'(x);
      dot(1'b0, 1'b0);
      checks++;
      if (pixel_OUT !== ((x < 8) ? 4'h0 : 4'hF)) begin
        errors++;
        $display("FAIL left_mask x=%0d got %h want %h", x, pixel_OUT, (x < 8) ? 4'h0 : 4'hF);
      end
    end
    showLeft8_EN      = 1'b1;
    showBackground_EN = 1'b0;
    for (int x = 0; x < 10; x++) begin
      pixelX_IN = 8'(x);
      dot(1'b0, 1'b0);
      checks++;
      if (pixel_OUT !== 4'h0 || opaque_OUT !== 1'b0) begin
        errors++;
        $display("FAIL bg_off x=%0d got %h/%b want 0/0", x, pixel_OUT, opaque_OUT);
      end
    end
    showBackground_EN = 1'b1;
  endtask

  task automatic test_enable_gating();
    do_reset();
    load_tile(8'hA5, 8'h0F, 2'b10);
    for (int i = 0; i < 9; i++) dot(1'b1, 1'b0);
    checks++;
    if (pixel_OUT !== 4'h9 || dut.pat_low !== 16'h4A00) begin
      errors++;
      $display("FAIL gate_pre got %h/%h want 9/4a00", pixel_OUT, dut.pat_low);
    end
    clock_EN  = 1'b0;
    shift_EN  = 1'b1;
    reload_EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (pixel_OUT !== 4'h9 || dut.pat_low !== 16'h4A00) begin
        errors++;
        $display("FAIL gate_hold cycle %0d got %h/%h want 9/4a00", i, pixel_OUT, dut.pat_low);
      end
    end
    dot(1'b1, 1'b0);
    checks++;
    if (pixel_OUT !== 4'h0) begin
      errors++;
      $display("FAIL gate_resume col1 got %h want 0", pixel_OUT);
    end
    dot(1'b1, 1'b0);
    dot(1'b1, 1'b0);
    dot(1'b1, 1'b0);
    checks++;
    if (pixel_OUT !== 4'hA) begin
      errors++;
      $display("FAIL gate_resume col4 got %h want a", pixel_OUT);
    end
  endtask

  initial begin
    reset_N = 1'b1;
    test_reset();
    test_basic_tile();
    test_fine_x();
    test_shift_reload();
    test_left_mask();
    test_enable_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
